// File: rtl/pdm_decimador.sv
// Boxcar PDM decimator: counts the ones in each window of DECIM bits and emits
// one unsigned PCM sample per window on a valid/ready port. A finished window
// that meets an unconsumed sample is dropped and counted.
module pdm_decimador #(
  parameter int DECIM  = 64,
  parameter int OUT_W  = 7,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [OUT_W-1:0]  pcm_data,
  output logic              pcm_valid,
  input  logic              pcm_ready,
  output logic              overrun,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int CW = $clog2(DECIM);

  logic [CW-1:0]    bit_cnt;
  logic [OUT_W-1:0] ones_acc;
  logic             take, last;
  logic [OUT_W-1:0] sample;

  // Window bookkeeping; the last bit is folded into the sample directly.
  always_comb begin
    take   = en & bit_valid;
    last   = take && (bit_cnt == CW'(DECIM - 1));
    sample = ones_acc + OUT_W'(bit_in);
  end

  // Window accumulator: en=0 holds it cleared so re-enable starts fresh.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      bit_cnt  <= '0;
      ones_acc <= '0;
    end else if (take) begin
      if (last) begin
        bit_cnt  <= '0;
        ones_acc <= '0;
      end else begin
        bit_cnt  <= bit_cnt + 1'b1;
        ones_acc <= sample;
      end
    end
  end

  // Output register with handshake, drop accounting and saturating counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
      drop_cnt  <= '0;
    end else if (last) begin
      if (!pcm_valid || pcm_ready) begin
        pcm_data  <= sample;
        pcm_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (pcm_valid && pcm_ready) begin
      pcm_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pdm_decimador.sv
// Scoreboard bench for pdm_decimador (DECIM=8, OUT_W=4, DROP_W=3).
module tb_pdm_decimador;
  localparam int DECIM = 8, OUT_W = 4, DROP_W = 3;

  logic              clk = 0, reset = 1, en = 1, bit_in = 0, bit_valid = 0, pcm_ready = 1;
  logic [OUT_W-1:0]  pcm_data;
  logic              pcm_valid, overrun;
  logic [DROP_W-1:0] drop_cnt;

  int tests = 0, fails = 0;
  int exp_q[$];

  pdm_decimador #(.DECIM(DECIM), .OUT_W(OUT_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
    .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
    .overrun(overrun), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every transfer must match the next expected sample.
  always @(negedge clk) begin
    if (!reset && pcm_valid && pcm_ready) begin
      if (exp_q.size() == 0) chk("unexpected_sample", int'(pcm_data), -1);
      else chk("pcm_sample", int'(pcm_data), exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b);
    bit_in = b; bit_valid = 1;
    @(posedge clk); #1;
    bit_valid = 0;
  endtask

  task automatic send_pat(input logic [7:0] pat);  // MSB first
    for (int i = 7; i >= 0; i--) send_bit(pat[i]);
  endtask

  task automatic do_reset(input string tag);
    reset = 1; idle(1); reset = 0;
    chk({tag, "_rst_valid"}, pcm_valid, 0);
    chk({tag, "_rst_data"}, pcm_data, 0);
    chk({tag, "_rst_overrun"}, overrun, 0);
    chk({tag, "_rst_drop"}, drop_cnt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    do_reset("t0");

    // 1: sparse strobes, all ones then all zeros; one-cycle latency.
    exp_q.push_back(8);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("t1_valid_before", pcm_valid, 0);
      send_bit(1);
      if (i < 7) idle(3);
    end
    chk("t1_valid_after_last", pcm_valid, 1);
    chk("t1_data8", pcm_data, 8);
    idle(1);
    chk("t1_valid_drop", pcm_valid, 0);
    exp_q.push_back(0);
    for (int i = 0; i < 8; i++) begin send_bit(0); idle(3); end
    chk("t1_data0", pcm_data, 0);

    // 2: 1,0 pattern, back-to-back strobes, three windows.
    repeat (3) exp_q.push_back(4);
    repeat (3) send_pat(8'b1010_1010);
    idle(2);
    chk("t2_drained", exp_q.size(), 0);

    // 3: sink stalled for three all-ones windows.
    pcm_ready = 0;
    exp_q.push_back(8);
    repeat (3) send_pat(8'hFF);
    chk("t3_valid", pcm_valid, 1);
    chk("t3_data", pcm_data, 8);
    chk("t3_overrun", overrun, 1);
    chk("t3_drop", drop_cnt, 2);
    pcm_ready = 1;
    idle(1);
    chk("t3_valid_after", pcm_valid, 0);
    chk("t3_drained", exp_q.size(), 0);

    // 4: ready only on the cycle the 2nd window ends.
    do_reset("t4");
    pcm_ready = 0;
    exp_q.push_back(8);
    send_pat(8'hFF);
    exp_q.push_back(3);
    for (int i = 0; i < 7; i++) send_bit(i < 3);
    pcm_ready = 1;
    send_bit(0);
    pcm_ready = 0;
    chk("t4_valid", pcm_valid, 1);
    chk("t4_data", pcm_data, 3);
    chk("t4_overrun", overrun, 0);
    chk("t4_drop", drop_cnt, 0);
    pcm_ready = 1;
    idle(1);
    chk("t4_valid_after", pcm_valid, 0);

    // 5: reset mid-window, then saturation of drop counter.
    for (int i = 0; i < 5; i++) send_bit(1);
    do_reset("t5");
    exp_q.push_back(8);
    send_pat(8'hFF);
    chk("t5_data", pcm_data, 8);
    idle(1);
    pcm_ready = 0;
    exp_q.push_back(5);
    send_pat(8'b1111_1000);
    repeat (10) send_pat(8'hFF);
    chk("t5_data_held", pcm_data, 5);
    chk("t5_overrun", overrun, 1);
    chk("t5_drop_sat", drop_cnt, 7);
    pcm_ready = 1;
    idle(1);
    chk("t5_drained", exp_q.size(), 0);

    // 6: en=0 mid-window clears it and ignores strobes.
    for (int i = 0; i < 3; i++) send_bit(1);
    en = 0;
    idle(1);
    for (int i = 0; i < 4; i++) send_bit(1);
    chk("t6_no_sample", pcm_valid, 0);
    en = 1;
    exp_q.push_back(8);
    for (int i = 0; i < 7; i++) send_bit(1);
    chk("t6_not_early", pcm_valid, 0);
    send_bit(1);
    chk("t6_valid", pcm_valid, 1);
    chk("t6_data", pcm_data, 8);
    idle(2);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_overrun_sticky", overrun, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
